// File: rtl/layer_serializer_if.sv
// Parallel-to-serial layer link: upstream lane vector in, {addr, data, valid} stream out.
// master = upstream/consumer side, slave = the serializer.
interface layer_serializer_if #(
  parameter int NUM_VALUES = 128,
  parameter int IN_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
);
  logic [NUM_VALUES-1:0]          in_valids;
  logic [NUM_VALUES*IN_WIDTH-1:0] layer_in;
  logic                           pause;
  logic [ADDR_WIDTH-1:0]          local_addr;
  logic [IN_WIDTH-1:0]            data_out;
  logic                           out_valid;
  logic                           busy;
  logic                           done;

  modport master (
    output in_valids, layer_in, pause,
    input  local_addr, data_out, out_valid, busy, done
  );

  modport slave (
    input  in_valids, layer_in, pause,
    output local_addr, data_out, out_valid, busy, done
  );
endinterface

// File: rtl/layer_serializer.sv
// Captures a full layer result vector on the rising edge of "all lanes valid" and
// replays it one lane per cycle, with local_addr leading data by one cycle.
module layer_serializer_lane #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     q_q <= '0;
    else if (load_i) q_q <= d_i;
  end

  assign q_o = q_q;
endmodule

module layer_serializer #(
  parameter int NUM_VALUES = 128,
  parameter int IN_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  layer_serializer_if.slave     bus
);
  localparam int IDX_W = (NUM_VALUES > 1) ? $clog2(NUM_VALUES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VALUES - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [IN_WIDTH-1:0]                 data_q, data_d;
  logic                                out_valid_q, out_valid_d;
  logic                                done_q, done_d;
  logic                                all_d_q;
  logic                                all_valid;
  logic                                trigger;
  logic                                load;
  logic [NUM_VALUES-1:0][IN_WIDTH-1:0] lane_q;

  assign all_valid = &bus.in_valids;
  // Edge-triggered so a level left high after a vector never restarts the stream.
  assign trigger   = all_valid & ~all_d_q;
  assign load      = (state_q == IDLE) && trigger;

  for (genvar g = 0; g < NUM_VALUES; g++) begin : g_lane
    layer_serializer_lane #(.W(IN_WIDTH)) u_lane (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .load_i (load),
      .d_i    (bus.layer_in[g*IN_WIDTH +: IN_WIDTH]),
      .q_o    (lane_q[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      all_d_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      all_d_q     <= all_valid;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    data_d      = data_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          idx_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        // On pause idx and data stay put, so the addressed memory word stays stable.
        if (!bus.pause) begin
          data_d      = lane_q[idx_q];
          out_valid_d = 1'b1;
          if (idx_q == LAST_IDX) begin
            done_d  = 1'b1;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.local_addr = (state_q == STREAM) ? ADDR_WIDTH'(idx_q) : '0;
  assign bus.busy       = (state_q == STREAM);
  assign bus.data_out   = data_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.done       = done_q;
endmodule

// File: tb/tb_layer_serializer.sv
// Directed bench for layer_serializer with 4 lanes of 4 bits.
module tb_layer_serializer;
  localparam int NV = 4;
  localparam int IW = 4;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  layer_serializer_if #(.NUM_VALUES(NV), .IN_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  layer_serializer #(.NUM_VALUES(NV), .IN_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full observation of the output side.
  task automatic exp_out(input string tag, input logic [31:0] addr, input logic ov,
                         input logic [3:0] data, input logic busy, input logic done);
    chk({tag, ".addr"}, bus.local_addr, addr);
    chk({tag, ".ov"},   {31'd0, bus.out_valid}, {31'd0, ov});
    chk({tag, ".data"}, {28'd0, bus.data_out}, {28'd0, data});
    chk({tag, ".busy"}, {31'd0, bus.busy}, {31'd0, busy});
    chk({tag, ".done"}, {31'd0, bus.done}, {31'd0, done});
  endtask

  initial begin
    bus.in_valids = '0;
    bus.layer_in  = '0;
    bus.pause     = 1'b0;
    tick(); tick();
    exp_out("reset", 0, 0, 4'h0, 0, 0);
    rst_n = 1'b1;
    tick();
    exp_out("post_reset", 0, 0, 4'h0, 0, 0);

    // 1. basic stream: lanes A,0,7,D
    bus.layer_in  = 16'hD70A;
    bus.in_valids = 4'hF;
    tick(); exp_out("t1.trig", 0, 0, 4'h0, 1, 0);
    tick(); exp_out("t1.b0",   1, 1, 4'hA, 1, 0);
    tick(); exp_out("t1.b1",   2, 1, 4'h0, 1, 0);
    tick(); exp_out("t1.b2",   3, 1, 4'h7, 1, 0);
    tick(); exp_out("t1.b3",   0, 1, 4'hD, 0, 1);
    tick(); exp_out("t1.end",  0, 0, 4'hD, 0, 0);

    // 3a. level held high: no restart
    for (int i = 0; i < 3; i++) begin
      tick(); exp_out("t3.hold", 0, 0, 4'hD, 0, 0);
    end

    // 2. pause after beat 0 for two cycles
    bus.in_valids = 4'h0;
    tick();
    bus.in_valids = 4'hF;
    tick(); exp_out("t2.trig", 0, 0, 4'hD, 1, 0);
    tick(); exp_out("t2.b0",   1, 1, 4'hA, 1, 0);
    bus.pause = 1'b1;
    tick(); exp_out("t2.p0",   1, 0, 4'hA, 1, 0);
    tick(); exp_out("t2.p1",   1, 0, 4'hA, 1, 0);
    bus.pause = 1'b0;
    tick(); exp_out("t2.b1",   2, 1, 4'h0, 1, 0);
    tick(); exp_out("t2.b2",   3, 1, 4'h7, 1, 0);
    tick(); exp_out("t2.b3",   0, 1, 4'hD, 0, 1);
    tick(); exp_out("t2.end",  0, 0, 4'hD, 0, 0);

    // 3b. drop to 7 then back to F: new capture (lanes 4,3,2,1)
    bus.in_valids = 4'h7;
    tick(); exp_out("t3.low", 0, 0, 4'hD, 0, 0);
    bus.layer_in  = 16'h1234;
    bus.in_valids = 4'hF;
    tick(); exp_out("t3.trig", 0, 0, 4'hD, 1, 0);
    tick(); exp_out("t3.b0",   1, 1, 4'h4, 1, 0);
    tick(); exp_out("t3.b1",   2, 1, 4'h3, 1, 0);
    tick(); exp_out("t3.b2",   3, 1, 4'h2, 1, 0);
    // rising edge lands in the done cycle: accepted, one gap cycle
    bus.in_valids = 4'h0;
    tick(); exp_out("t3.b3",   0, 1, 4'h1, 0, 1);
    bus.layer_in  = 16'h5678;
    bus.in_valids = 4'hF;
    tick(); exp_out("bb.trig", 0, 0, 4'h1, 1, 0);
    tick(); exp_out("bb.b0",   1, 1, 4'h8, 1, 0);
    tick(); exp_out("bb.b1",   2, 1, 4'h7, 1, 0);
    tick(); exp_out("bb.b2",   3, 1, 4'h6, 1, 0);
    tick(); exp_out("bb.b3",   0, 1, 4'h5, 0, 1);

    // 4. partial valid never starts a stream
    bus.in_valids = 4'hE;
    for (int i = 0; i < 10; i++) begin
      tick(); exp_out("t4.part", 0, 0, 4'h5, 0, 0);
    end

    // 5. retrigger while busy is ignored
    bus.layer_in  = 16'hD70A;
    bus.in_valids = 4'hF;
    tick(); exp_out("t5.trig", 0, 0, 4'h5, 1, 0);
    tick(); exp_out("t5.b0",   1, 1, 4'hA, 1, 0);
    bus.layer_in  = 16'hFFFF;
    bus.in_valids = 4'h0;
    tick(); exp_out("t5.b1",   2, 1, 4'h0, 1, 0);
    bus.in_valids = 4'hF;
    tick(); exp_out("t5.b2",   3, 1, 4'h7, 1, 0);
    tick(); exp_out("t5.b3",   0, 1, 4'hD, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(); exp_out("t5.norst", 0, 0, 4'hD, 0, 0);
    end

    // 6. async reset mid-stream after beat index 1
    bus.in_valids = 4'h0;
    bus.layer_in  = 16'hD70A;
    tick();
    bus.in_valids = 4'hF;
    tick(); exp_out("t6.trig", 0, 0, 4'hD, 1, 0);
    tick(); exp_out("t6.b0",   1, 1, 4'hA, 1, 0);
    tick(); exp_out("t6.b1",   2, 1, 4'h0, 1, 0);
    #2 rst_n = 1'b0;
    bus.in_valids = 4'h0;
    #1 exp_out("t6.rst", 0, 0, 4'h0, 0, 0);
    tick(); exp_out("t6.rsth", 0, 0, 4'h0, 0, 0);
    rst_n = 1'b1;
    tick(); exp_out("t6.nodone", 0, 0, 4'h0, 0, 0);
    bus.layer_in  = 16'h9C3B;
    bus.in_valids = 4'hF;
    tick(); exp_out("t6.trig2", 0, 0, 4'h0, 1, 0);
    tick(); exp_out("t6.c0",    1, 1, 4'hB, 1, 0);
    tick(); exp_out("t6.c1",    2, 1, 4'h3, 1, 0);
    tick(); exp_out("t6.c2",    3, 1, 4'hC, 1, 0);
    tick(); exp_out("t6.c3",    0, 1, 4'h9, 0, 1);
    tick(); exp_out("t6.end",   0, 0, 4'h9, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
